vc_input_buffer: RTL and testbench

Parametrised single virtual-channel input buffer for the NoC router input port, the successor of the fixed-format per-VC buffer. It stores flits of one packet at a time in a configurable-width, configurable-depth FIFO and runs the per-VC IDLE/VA/SA pipeline state machine. It adds hysteresis on/off flow control (or credit return), an occupancy count and sticky error reporting. One instance exists per VC inside the input port; its outputs feed the VC and switch allocators.

---
 rtl/vc_input_buffer.sv | 183 ++++++++++++++++++
 tb/tb_vc_input_buffer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_input_buffer.sv
// Single virtual-channel input buffer with IDLE/VA/SA pipeline FSM.
// Define VC_INPUT_BUFFER_CREDIT_EN for credit return instead of on/off.
module vc_input_buffer #(
    parameter int BUFFER_SIZE = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int VC_SIZE     = 2,
    parameter int PORT_WIDTH  = 3,
    parameter int ON_OFF_HIGH = BUFFER_SIZE - 2,
    parameter int ON_OFF_LOW  = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [1:0]                         label_i,
    input  logic [DATA_WIDTH-1:0]              data_i,
    input  logic                               write_i,
    input  logic                               read_i,
    input  logic [PORT_WIDTH-1:0]              out_port_i,
    input  logic                               vc_valid_i,
    input  logic [VC_SIZE-1:0]                 vc_new_i,
    output logic [1:0]                         label_o,
    output logic [DATA_WIDTH-1:0]              data_o,
    output logic [VC_SIZE-1:0]                 vc_id_o,
    output logic [PORT_WIDTH-1:0]              out_port_o,
    output logic [VC_SIZE-1:0]                 downstream_vc_o,
    output logic [$clog2(BUFFER_SIZE+1)-1:0]   count_o,
    output logic                               is_full_o,
    output logic                               is_empty_o,
    output logic                               on_off_o,
    output logic                               credit_o,
    output logic                               vc_request_o,
    output logic                               switch_request_o,
    output logic                               vc_allocatable_o,
    output logic                               err_o,
    output logic                               err_sticky_o
);

    localparam int PW = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam int CW = $clog2(BUFFER_SIZE + 1);

    localparam logic [1:0] HEAD     = 2'd0;
    localparam logic [1:0] TAIL     = 2'd2;
    localparam logic [1:0] HEADTAIL = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VA   = 2'd1,
        SA   = 2'd2
    } state_t;

    state_t                  state;
    logic                    end_packet;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           cnt_next;
    logic [DATA_WIDTH+1:0]   mem [BUFFER_SIZE];
    logic                    head_in;
    logic                    tail_out;
    logic                    wr_ok;
    logic                    rd_ok;
    logic                    err_next;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(BUFFER_SIZE - 1)) ? '0 : p + PW'(1);
    endfunction

    assign is_empty_o       = (count_o == '0);
    assign is_full_o        = (count_o == CW'(BUFFER_SIZE));
    assign {label_o, data_o} = is_empty_o ? '0 : mem[rd_ptr];
    assign vc_id_o          = downstream_vc_o;
    assign vc_request_o     = (state == VA);
    assign switch_request_o = (state == SA) && !is_empty_o;

    assign head_in  = (label_i == HEAD) || (label_i == HEADTAIL);
    assign tail_out = (label_o == TAIL) || (label_o == HEADTAIL);
    assign cnt_next = count_o + CW'(wr_ok) - CW'(rd_ok);

    // Any write or command not accepted here is an error and is dropped.
    always_comb begin
        wr_ok    = 1'b0;
        rd_ok    = 1'b0;
        err_next = 1'b0;
        case (state)
            IDLE: begin
                wr_ok    = write_i && head_in && is_empty_o;
                err_next = (write_i && !wr_ok) || read_i || vc_valid_i;
            end
            VA: begin
                wr_ok    = write_i && !head_in && !end_packet && !is_full_o;
                err_next = (write_i && !wr_ok) || read_i;
            end
            SA: begin
                rd_ok    = read_i && !is_empty_o;
                wr_ok    = write_i && !head_in && !end_packet
                           && (!is_full_o || rd_ok);
                err_next = (write_i && !wr_ok) || (read_i && !rd_ok)
                           || vc_valid_i;
            end
            default: err_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            end_packet       <= 1'b0;
            out_port_o       <= '0;
            downstream_vc_o  <= '0;
            vc_allocatable_o <= 1'b0;
        end else begin
            vc_allocatable_o <= 1'b0;
            case (state)
                IDLE: if (wr_ok) begin
                    state      <= VA;
                    out_port_o <= out_port_i;
                    end_packet <= (label_i == HEADTAIL);
                end
                VA: begin
                    if (wr_ok && label_i == TAIL) end_packet <= 1'b1;
                    if (vc_valid_i) begin
                        state           <= SA;
                        downstream_vc_o <= vc_new_i;
                    end
                end
                SA: begin
                    if (wr_ok && label_i == TAIL) end_packet <= 1'b1;
                    if (rd_ok && tail_out) begin
                        state            <= IDLE;
                        end_packet       <= 1'b0;
                        vc_allocatable_o <= 1'b1;
                    end
                end
                default: begin
                    state            <= IDLE;
                    end_packet       <= 1'b0;
                    vc_allocatable_o <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_o      <= '0;
            err_o        <= 1'b0;
            err_sticky_o <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wrap_inc(wr_ptr);
            if (rd_ok) rd_ptr <= wrap_inc(rd_ptr);
            count_o      <= cnt_next;
            err_o        <= err_next;
            err_sticky_o <= err_sticky_o || err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= {label_i, data_i};
    end

`ifdef VC_INPUT_BUFFER_CREDIT_EN
    assign on_off_o = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) credit_o <= 1'b0;
        else     credit_o <= rd_ok;
    end
`else
    assign credit_o = 1'b0;

    // Hysteresis band: hold the flag between the two thresholds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            on_off_o <= 1'b1;
        end else if (cnt_next >= CW'(ON_OFF_HIGH)) begin
            on_off_o <= 1'b0;
        end else if (cnt_next <= CW'(ON_OFF_LOW)) begin
            on_off_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vc_input_buffer.sv
// Scoreboard bench for vc_input_buffer: directed packet flows plus
// randomized traffic against a queue-based model of the buffer.
module tb_vc_input_buffer;

    localparam int BS   = 8;
    localparam int HIGH = BS - 2;
    localparam int LOW  = 2;

    localparam logic [1:0] L_HEAD = 2'd0;
    localparam logic [1:0] L_BODY = 2'd1;
    localparam logic [1:0] L_TAIL = 2'd2;
    localparam logic [1:0] L_HT   = 2'd3;

    logic        clk;
    logic        rst;
    logic [1:0]  label_i;
    logic [15:0] data_i;
    logic        write_i;
    logic        read_i;
    logic [2:0]  out_port_i;
    logic        vc_valid_i;
    logic [1:0]  vc_new_i;
    logic [1:0]  label_o;
    logic [15:0] data_o;
    logic [1:0]  vc_id_o;
    logic [2:0]  out_port_o;
    logic [1:0]  downstream_vc_o;
    logic [3:0]  count_o;
    logic        is_full_o;
    logic        is_empty_o;
    logic        on_off_o;
    logic        credit_o;
    logic        vc_request_o;
    logic        switch_request_o;
    logic        vc_allocatable_o;
    logic        err_o;
    logic        err_sticky_o;

    vc_input_buffer dut (
        .clk              (clk),
        .rst              (rst),
        .label_i          (label_i),
        .data_i           (data_i),
        .write_i          (write_i),
        .read_i           (read_i),
        .out_port_i       (out_port_i),
        .vc_valid_i       (vc_valid_i),
        .vc_new_i         (vc_new_i),
        .label_o          (label_o),
        .data_o           (data_o),
        .vc_id_o          (vc_id_o),
        .out_port_o       (out_port_o),
        .downstream_vc_o  (downstream_vc_o),
        .count_o          (count_o),
        .is_full_o        (is_full_o),
        .is_empty_o       (is_empty_o),
        .on_off_o         (on_off_o),
        .credit_o         (credit_o),
        .vc_request_o     (vc_request_o),
        .switch_request_o (switch_request_o),
        .vc_allocatable_o (vc_allocatable_o),
        .err_o            (err_o),
        .err_sticky_o     (err_sticky_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef enum {M_IDLE, M_VA, M_SA} mstate_t;

    mstate_t     ms;
    logic [17:0] fq[$];
    logic [17:0] sb[$];
    bit          ep;
    bit          m_on;
    bit          m_sticky;
    bit          e_err;
    bit          e_alloc;
    bit          e_credit;
    logic [2:0]  m_op;
    logic [1:0]  m_vc;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    // Flits leave the DUT whenever a grant meets a requesting VC.
    always @(negedge clk) begin
        if (!rst && read_i && switch_request_o) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL flit_out @%0t: got %0h expected none",
                         $time, {label_o, data_o});
            end else begin
                logic [17:0] exp;
                exp = sb.pop_front();
                if ({label_o, data_o} !== exp) begin
                    n_err++;
                    $display("FAIL flit_out @%0t: got %0h expected %0h",
                             $time, {label_o, data_o}, exp);
                end
            end
        end
    end

    task automatic check_outputs();
        logic [17:0] front;
        front = (fq.size() == 0) ? 18'h0 : fq[0];
        chk("count", 32'(count_o), 32'(fq.size()));
        chk("empty", 32'(is_empty_o), 32'(fq.size() == 0));
        chk("full", 32'(is_full_o), 32'(fq.size() == BS));
        chk("on_off", 32'(on_off_o), 32'(m_on));
        chk("credit", 32'(credit_o), 32'(e_credit));
        chk("err", 32'(err_o), 32'(e_err));
        chk("err_sticky", 32'(err_sticky_o), 32'(m_sticky));
        chk("vc_alloc", 32'(vc_allocatable_o), 32'(e_alloc));
        chk("vc_req", 32'(vc_request_o), 32'(ms == M_VA));
        chk("sw_req", 32'(switch_request_o),
            32'(ms == M_SA && fq.size() != 0));
        chk("out_port", 32'(out_port_o), 32'(m_op));
        chk("ds_vc", 32'(downstream_vc_o), 32'(m_vc));
        chk("vc_id", 32'(vc_id_o), 32'(m_vc));
        chk("head_flit", 32'({label_o, data_o}), 32'(front));
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        write_i    = 1'b0;
        read_i     = 1'b0;
        vc_valid_i = 1'b0;
        label_i    = 2'd0;
        data_i     = 16'd0;
        out_port_i = 3'd0;
        vc_new_i   = 2'd0;
        ms       = M_IDLE;
        fq.delete();
        sb.delete();
        ep       = 0;
        m_on     = 1;
        m_sticky = 0;
        e_err    = 0;
        e_alloc  = 0;
        e_credit = 0;
        m_op     = 3'd0;
        m_vc     = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;
    endtask

    task automatic step(input bit w, input logic [1:0] l, input bit rd,
                        input bit vv, input logic [1:0] vn,
                        input logic [2:0] op);
        logic [15:0] d;
        bit head;
        bit rd_acc;
        bit wr_acc;
        bit tail_pop;
        int n;
        d          = 16'($urandom);
        write_i    = w;
        label_i    = l;
        data_i     = d;
        read_i     = rd;
        vc_valid_i = vv;
        vc_new_i   = vn;
        out_port_i = op;
        head     = (l == L_HEAD) || (l == L_HT);
        n        = fq.size();
        rd_acc   = rd && ms == M_SA && n != 0;
        tail_pop = rd_acc && (fq[0][17:16] == L_TAIL || fq[0][17:16] == L_HT);
        if (ms == M_IDLE) wr_acc = w && head && n == 0;
        else wr_acc = w && !head && !ep && (n < BS || rd_acc);
        e_err   = (w && !wr_acc) || (rd && !rd_acc) || (vv && ms != M_VA);
        e_alloc = 0;
        if (rd_acc) void'(fq.pop_front());
        if (wr_acc) begin
            fq.push_back({l, d});
            sb.push_back({l, d});
            if (l == L_TAIL || l == L_HT) ep = 1;
        end
        case (ms)
            M_IDLE: if (wr_acc) begin ms = M_VA; m_op = op; end
            M_VA:   if (vv) begin ms = M_SA; m_vc = vn; end
            default: if (tail_pop) begin
                ms = M_IDLE;
                ep = 0;
                e_alloc = 1;
            end
        endcase
        m_sticky = m_sticky || e_err;
`ifdef VC_INPUT_BUFFER_CREDIT_EN
        e_credit = rd_acc;
        m_on     = 1;
`else
        e_credit = 0;
        if (fq.size() >= HIGH) m_on = 0;
        else if (fq.size() <= LOW) m_on = 1;
`endif
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic stp(input bit w, input logic [1:0] l, input bit rd,
                       input bit vv = 0, input logic [1:0] vn = 2'd0,
                       input logic [2:0] op = 3'd3);
        step(w, l, rd, vv, vn, op);
    endtask

    initial begin
        rst = 1'b1;
        #2;
        do_reset();

        // Four-flit packet through VA and SA
        stp(1, L_HEAD, 0);
        stp(1, L_BODY, 0);
        stp(1, L_BODY, 0);
        stp(1, L_TAIL, 0);
        stp(0, L_HEAD, 0, 1, 2'd2);
        repeat (4) stp(0, L_HEAD, 1);
        stp(0, L_HEAD, 0);

        // Single-flit packet; trailing body is an error
        stp(1, L_HT, 0, 0, 2'd0, 3'd5);
        stp(1, L_BODY, 0);
        stp(0, L_HEAD, 0, 1, 2'd1);
        stp(0, L_HEAD, 1);
        stp(0, L_HEAD, 0);

        // Hysteresis, full, simultaneous read/write across the wrap
        stp(1, L_HEAD, 0, 0, 2'd0, 3'd6);
        repeat (5) stp(1, L_BODY, 0);
        stp(0, L_HEAD, 0, 1, 2'd3);
        repeat (3) stp(0, L_HEAD, 1);
        stp(0, L_HEAD, 1);
        repeat (6) stp(1, L_BODY, 0);
        stp(1, L_BODY, 0);
        repeat (5) stp(1, L_BODY, 1);
        stp(1, L_TAIL, 1);
        repeat (8) stp(0, L_HEAD, 1);

        // Read of an empty FIFO in SA
        stp(1, L_HEAD, 0);
        stp(0, L_HEAD, 0, 1, 2'd0);
        stp(0, L_HEAD, 1);
        stp(0, L_HEAD, 1);
        stp(1, L_TAIL, 0);
        stp(0, L_HEAD, 1);
        stp(0, L_HEAD, 0);
        do_reset();

        for (int i = 0; i < 1500; i++) begin
            bit w;
            bit rd;
            bit vv;
            logic [1:0] l;
            int r;
            w = ($urandom % 3) != 0;
            r = $urandom % 10;
            if (ms == M_IDLE)
                l = (r < 2) ? 2'($urandom_range(3))
                            : ((r < 6) ? L_HEAD : L_HT);
            else
                l = (r < 6) ? L_BODY
                            : ((r < 8) ? L_TAIL : 2'($urandom_range(3)));
            rd = (ms == M_SA) ? ($urandom % 2 == 0) : ($urandom % 20 == 0);
            vv = (ms == M_VA) ? ($urandom % 3 == 0) : ($urandom % 25 == 0);
            step(w, l, rd, vv, 2'($urandom), 3'($urandom));
            if (i % 500 == 499) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
